// File: rtl/reg_alu_seq.sv
// Instruction sequencer feeding the register-file/ALU datapath: decodes NOP/LOADI/ALU/HALT
// words received over valid/ready and steps the datapath controls through each instruction.
module reg_alu_seq #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             instr_valid,
  input  logic [15:0]      instr,
  output logic             instr_ready,
  input  logic             cout_in,
  output logic             sel,
  output logic             wr,
  output logic [1:0]       op,
  output logic [2:0]       rd_addr_a,
  output logic [2:0]       rd_addr_b,
  output logic [2:0]       wr_addr,
  output logic [15:0]      d_in,
  output logic             carry_flag,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_LDATA,
    S_EXEC,
    S_WB_ALU,
    S_WB_LD,
    S_HALT
  } state_t;

  state_t      state, state_nxt;
  logic        xfer;
  logic        retire;
  logic [1:0]  op_q;
  logic [2:0]  rd_q, ra_q, rb_q;
  logic [15:0] imm_q;

  assign instr_ready = ~reset & ((state == S_FETCH) | (state == S_LDATA));
  assign xfer        = instr_valid & instr_ready;

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    sel       = 1'b0;
    wr        = 1'b0;
    op        = 2'b00;
    rd_addr_a = 3'd0;
    rd_addr_b = 3'd0;
    wr_addr   = 3'd0;
    d_in      = 16'h0000;
    halted    = 1'b0;
    case (state)
      S_FETCH: begin
        if (xfer) begin
          case (instr[15:14])
            2'b00:   state_nxt = S_FETCH;
            2'b01:   state_nxt = S_LDATA;
            2'b10:   state_nxt = S_EXEC;
            default: state_nxt = S_HALT;
          endcase
        end
      end
      S_LDATA: begin
        if (xfer) state_nxt = S_WB_LD;
      end
      S_EXEC: begin
        sel       = 1'b1;
        op        = op_q;
        rd_addr_a = ra_q;
        rd_addr_b = rb_q;
        state_nxt = S_WB_ALU;
      end
      S_WB_ALU: begin
        sel       = 1'b1;
        wr        = 1'b1;
        op        = op_q;
        rd_addr_a = ra_q;
        rd_addr_b = rb_q;
        wr_addr   = rd_q;
        state_nxt = S_FETCH;
      end
      S_WB_LD: begin
        wr        = 1'b1;
        wr_addr   = rd_q;
        d_in      = imm_q;
        state_nxt = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: state_nxt = S_FETCH;
    endcase
  end

  // Decoded fields and immediate are plain data: no reset, outputs gate them by state.
  always_ff @(posedge clk) begin
    if (state == S_FETCH && xfer) begin
      op_q <= instr[13:12];
      ra_q <= instr[8:6];
      rb_q <= instr[5:3];
      rd_q <= (instr[15:14] == 2'b01) ? instr[13:11] : instr[11:9];
    end
    if (state == S_LDATA && xfer) imm_q <= instr;
  end

  assign retire = (state == S_WB_LD) | (state == S_WB_ALU) |
                  ((state == S_FETCH) & xfer & (instr[15:14] == 2'b00));

  always_ff @(posedge clk) begin
    if (reset) begin
      retired    <= '0;
      carry_flag <= 1'b0;
    end else begin
      if (retire)             retired    <= retired + CNT_W'(1);
      if (state == S_WB_ALU)  carry_flag <= cout_in;
    end
  end

endmodule

// File: tb/tb_reg_alu_seq.sv
// Bench for reg_alu_seq: directed vector table plus randomized traffic against a
// transaction-level reference model (queue of pending datapath control cycles).
module tb_reg_alu_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, instr_valid, cout_in;
  logic [15:0] instr;

  logic        instr_ready, sel, wr, carry_flag, halted;
  logic [1:0]  op;
  logic [2:0]  rd_addr_a, rd_addr_b, wr_addr;
  logic [15:0] d_in;
  logic [7:0]  retired;

  logic        instr_ready2, sel2, wr2, carry_flag2, halted2;
  logic [1:0]  op2;
  logic [2:0]  rd_addr_a2, rd_addr_b2, wr_addr2;
  logic [15:0] d_in2;
  logic [1:0]  retired2;

  reg_alu_seq #(.CNT_W(8)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .cout_in(cout_in), .sel(sel), .wr(wr), .op(op),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .wr_addr(wr_addr), .d_in(d_in),
    .carry_flag(carry_flag), .halted(halted), .retired(retired)
  );

  reg_alu_seq #(.CNT_W(2)) dut_w2 (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready2), .cout_in(cout_in), .sel(sel2), .wr(wr2), .op(op2),
    .rd_addr_a(rd_addr_a2), .rd_addr_b(rd_addr_b2), .wr_addr(wr_addr2), .d_in(d_in2),
    .carry_flag(carry_flag2), .halted(halted2), .retired(retired2)
  );

  typedef struct {
    logic        sel, wr;
    logic [1:0]  op;
    logic [2:0]  ra, rb, wa;
    logic [15:0] din;
    logic        alu_wb;
  } ctl_t;

  typedef struct {
    logic        rst, v;
    logic [15:0] ins;
    logic        cout;
    logic        rdy, wr, sel;
    logic [1:0]  op;
    logic [2:0]  ra, rb, wa;
    logic [15:0] din;
    logic        halted;
    logic [7:0]  ret;
    logic        carry;
  } vec_t;

  ctl_t     pend[$];
  bit       await_m = 0, halt_m = 0, carry_m = 0;
  logic [2:0] ld_rd = 3'd0;
  int       ret_m = 0;
  int       errors = 0, checks = 0;
  vec_t     vt[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic check_model();
    ctl_t e;
    bit   rdy_m;
    if (pend.size() > 0) e = pend[0];
    else e = '{sel: 1'b0, wr: 1'b0, op: 2'd0, ra: 3'd0, rb: 3'd0, wa: 3'd0, din: 16'h0, alu_wb: 1'b0};
    rdy_m = !reset && !halt_m && (pend.size() == 0);
    chk("ready",      32'(instr_ready), 32'(rdy_m));
    chk("sel",        32'(sel),         32'(e.sel));
    chk("wr",         32'(wr),          32'(e.wr));
    chk("op",         32'(op),          32'(e.op));
    chk("rd_addr_a",  32'(rd_addr_a),   32'(e.ra));
    chk("rd_addr_b",  32'(rd_addr_b),   32'(e.rb));
    chk("wr_addr",    32'(wr_addr),     32'(e.wa));
    chk("d_in",       32'(d_in),        32'(e.din));
    chk("carry_flag", 32'(carry_flag),  32'(carry_m));
    chk("halted",     32'(halted),      32'(halt_m));
    chk("retired",    32'(retired),     32'(ret_m % 256));
    chk("retired_w2", 32'(retired2),    32'(ret_m % 4));
  endtask

  task automatic model_update();
    ctl_t c;
    if (reset) begin
      pend.delete();
      await_m = 0; halt_m = 0; carry_m = 0; ret_m = 0;
    end else if (pend.size() > 0) begin
      c = pend.pop_front();
      if (c.wr) ret_m++;
      if (c.alu_wb) carry_m = cout_in;
    end else if (!halt_m && instr_valid) begin
      if (await_m) begin
        pend.push_back('{sel: 1'b0, wr: 1'b1, op: 2'd0, ra: 3'd0, rb: 3'd0, wa: ld_rd,
                         din: instr, alu_wb: 1'b0});
        await_m = 0;
      end else begin
        case (instr[15:14])
          2'b00: ret_m++;
          2'b01: begin await_m = 1; ld_rd = instr[13:11]; end
          2'b10: begin
            pend.push_back('{sel: 1'b1, wr: 1'b0, op: instr[13:12], ra: instr[8:6],
                             rb: instr[5:3], wa: 3'd0, din: 16'h0, alu_wb: 1'b0});
            pend.push_back('{sel: 1'b1, wr: 1'b1, op: instr[13:12], ra: instr[8:6],
                             rb: instr[5:3], wa: instr[11:9], din: 16'h0, alu_wb: 1'b1});
          end
          default: halt_m = 1;
        endcase
      end
    end
  endtask

  task automatic step(input bit use_tab, input vec_t t, input int row);
    string s;
    @(negedge clk);
    check_model();
    if (use_tab) begin
      s = $sformatf("row%0d", row);
      chk({s, "_ready"},  32'(instr_ready), 32'(t.rdy));
      chk({s, "_wr"},     32'(wr),          32'(t.wr));
      chk({s, "_sel"},    32'(sel),         32'(t.sel));
      chk({s, "_op"},     32'(op),          32'(t.op));
      chk({s, "_ra"},     32'(rd_addr_a),   32'(t.ra));
      chk({s, "_rb"},     32'(rd_addr_b),   32'(t.rb));
      chk({s, "_wa"},     32'(wr_addr),     32'(t.wa));
      chk({s, "_din"},    32'(d_in),        32'(t.din));
      chk({s, "_halted"}, 32'(halted),      32'(t.halted));
      chk({s, "_ret"},    32'(retired),     32'(t.ret));
      chk({s, "_ret_w2"}, 32'(retired2),    32'(t.ret[1:0]));
      chk({s, "_carry"},  32'(carry_flag),  32'(t.carry));
    end
    @(posedge clk);
    model_update();
    #1;
  endtask

  initial begin
    vec_t none;
    int   k;
    none = '{default: 0};
    // rst v instr cout | rdy wr sel op ra rb wa din halted ret carry
    vt.push_back('{1,1,16'h5800,0, 0,0,0,0,0,0,0,16'h0000,0,0,0});
    vt.push_back('{0,1,16'h5800,0, 1,0,0,0,0,0,0,16'h0000,0,0,0});
    vt.push_back('{0,1,16'hBEEF,0, 1,0,0,0,0,0,0,16'h0000,0,0,0});
    vt.push_back('{0,1,16'h0000,0, 0,1,0,0,0,0,3,16'hBEEF,0,0,0});
    vt.push_back('{0,1,16'h9AD0,0, 1,0,0,0,0,0,0,16'h0000,0,1,0});
    vt.push_back('{0,0,16'h0000,0, 0,0,1,1,3,2,0,16'h0000,0,1,0});
    vt.push_back('{0,0,16'h0000,1, 0,1,1,1,3,2,5,16'h0000,0,1,0});
    vt.push_back('{0,1,16'h7000,0, 1,0,0,0,0,0,0,16'h0000,0,2,1});
    for (int i = 0; i < 4; i++)
      vt.push_back('{0,0,16'h1111,0, 1,0,0,0,0,0,0,16'h0000,0,2,1});
    vt.push_back('{0,1,16'h1234,0, 1,0,0,0,0,0,0,16'h0000,0,2,1});
    vt.push_back('{0,0,16'h0000,0, 0,1,0,0,0,0,6,16'h1234,0,2,1});
    vt.push_back('{0,1,16'h0000,0, 1,0,0,0,0,0,0,16'h0000,0,3,1});
    vt.push_back('{0,1,16'h0000,0, 1,0,0,0,0,0,0,16'h0000,0,4,1});
    vt.push_back('{0,1,16'h0000,0, 1,0,0,0,0,0,0,16'h0000,0,5,1});
    vt.push_back('{0,0,16'h0000,0, 1,0,0,0,0,0,0,16'h0000,0,6,1});
    vt.push_back('{0,1,16'hC000,0, 1,0,0,0,0,0,0,16'h0000,0,6,1});
    vt.push_back('{0,1,16'h9AD0,0, 0,0,0,0,0,0,0,16'h0000,1,6,1});
    vt.push_back('{0,1,16'h9AD0,0, 0,0,0,0,0,0,0,16'h0000,1,6,1});
    vt.push_back('{1,1,16'h9AD0,0, 0,0,0,0,0,0,0,16'h0000,1,6,1});
    vt.push_back('{0,0,16'h0000,0, 1,0,0,0,0,0,0,16'h0000,0,0,0});
    vt.push_back('{0,1,16'h9AD0,0, 1,0,0,0,0,0,0,16'h0000,0,0,0});
    vt.push_back('{1,0,16'h0000,1, 0,0,1,1,3,2,0,16'h0000,0,0,0});
    vt.push_back('{0,0,16'h0000,0, 1,0,0,0,0,0,0,16'h0000,0,0,0});
    vt.push_back('{0,0,16'h0000,0, 1,0,0,0,0,0,0,16'h0000,0,0,0});
    vt.push_back('{0,1,16'hBE48,0, 1,0,0,0,0,0,0,16'h0000,0,0,0});
    vt.push_back('{0,0,16'h0000,0, 0,0,1,3,1,1,0,16'h0000,0,0,0});
    vt.push_back('{1,0,16'h0000,1, 0,1,1,3,1,1,7,16'h0000,0,0,0});
    vt.push_back('{0,0,16'h0000,0, 1,0,0,0,0,0,0,16'h0000,0,0,0});

    reset = 1'b1; instr_valid = 1'b0; instr = 16'h0; cout_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < vt.size(); i++) begin
      reset = vt[i].rst; instr_valid = vt[i].v; instr = vt[i].ins; cout_in = vt[i].cout;
      step(1'b1, vt[i], i);
    end

    for (int n = 0; n < 3000; n++) begin
      reset       = ($urandom_range(0, 99) < 2);
      instr_valid = ($urandom_range(0, 9) < 7);
      cout_in     = 1'($urandom);
      k = $urandom_range(0, 19);
      instr[13:0] = 14'($urandom);
      if (k == 0)      instr[15:14] = 2'b11;
      else if (k < 6)  instr[15:14] = 2'b00;
      else if (k < 11) instr[15:14] = 2'b01;
      else             instr[15:14] = 2'b10;
      step(1'b0, none, n);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
